// File: rtl/sync_counter_gen.sv
// Fully synchronous up/down counter with modulo limit, prescaler, parallel load,
// terminal-count pulse and sticky overflow flag. All state moves on one clk edge.
module sync_counter_gen #(
    parameter int WIDTH    = 65,
    parameter int PRESC_W  = 8,
    parameter int SATURATE = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               up,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [WIDTH-1:0]   limit,
    input  logic [PRESC_W-1:0] presc_div,
    input  logic               clear_ovf,
    output logic [WIDTH-1:0]   q,
    output logic               tick,
    output logic               tc,
    output logic               ovf
);

    localparam logic [WIDTH-1:0]   Q_ONE = WIDTH'(1);
    localparam logic [PRESC_W-1:0] P_ONE = PRESC_W'(1);
    localparam bit                 SAT   = (SATURATE != 0);

    logic [PRESC_W-1:0] p;
    logic               step;
    logic [WIDTH-1:0]   q_step;
    logic               tc_step;

    // ">=" rather than "==" so a presc_div lowered below p still produces a step.
    assign step = en && !load && (p >= presc_div);

    always_comb begin
        q_step  = q;
        tc_step = 1'b0;
        if (up) begin
            if (q < limit) begin
                q_step = q + Q_ONE;
            end else begin
                tc_step = 1'b1;
                q_step  = SAT ? limit : '0;
            end
        end else begin
            if (q > limit) begin
                // limit was lowered under a running count: snap back into range quietly
                q_step = limit;
            end else if (q == '0) begin
                tc_step = 1'b1;
                q_step  = SAT ? '0 : limit;
            end else begin
                q_step = q - Q_ONE;
            end
        end
    end

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values; blocking would chain them combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= '0;
            p    <= '0;
            tick <= 1'b0;
            tc   <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            tick <= 1'b0;
            tc   <= 1'b0;
            if (load) begin
                q <= (load_val < limit) ? load_val : limit;
                p <= '0;
            end else if (step) begin
                q    <= q_step;
                p    <= '0;
                tick <= 1'b1;
                tc   <= tc_step;
            end else if (en) begin
                p <= p + P_ONE;
            end
            // a terminal count on this edge wins over a simultaneous clear
            if (step && tc_step) begin
                ovf <= 1'b1;
            end else if (clear_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_counter_gen.sv
// Scoreboard bench: a wrap-mode and a saturate-mode counter share stimulus; an
// arithmetic reference model queues expected outputs that a monitor compares.
module tb_sync_counter_gen;

    localparam int W  = 65;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          reset, en, up, load, clear_ovf;
    logic [W-1:0]  load_val, limit;
    logic [PW-1:0] presc_div;

    logic [W-1:0]  q_w, q_s;
    logic          tick_w, tc_w, ovf_w, tick_s, tc_s, ovf_s;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0] q;
        logic         tick;
        logic         tc;
        logic         ovf;
    } exp_t;

    exp_t exp_q[2][$];

    // reference state, index 0 = wrap, 1 = saturate
    logic [W-1:0]  mq   [2];
    int unsigned   mcnt [2];
    logic          movf [2];

    always #5 clk = ~clk;

    sync_counter_gen #(.WIDTH(W), .PRESC_W(PW), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .limit(limit), .presc_div(presc_div), .clear_ovf(clear_ovf),
        .q(q_w), .tick(tick_w), .tc(tc_w), .ovf(ovf_w)
    );

    sync_counter_gen #(.WIDTH(W), .PRESC_W(PW), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .limit(limit), .presc_div(presc_div), .clear_ovf(clear_ovf),
        .q(q_s), .tick(tick_s), .tc(tc_s), .ovf(ovf_s)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Count range is treated as the ring 0..limit of size limit+1.
    task automatic model_edge(input int s, output exp_t e);
        logic [W:0]   range, t;
        logic         sat, boundary;
        logic [W-1:0] nq;
        sat   = (s == 1);
        range = {1'b0, limit} + (W+1)'(1);
        e     = '0;
        if (reset) begin
            mq[s] = '0; mcnt[s] = 0; movf[s] = 1'b0;
        end else begin
            if (load) begin
                mq[s]   = (load_val < limit) ? load_val : limit;
                mcnt[s] = 0;
            end else if (en) begin
                if (mcnt[s] >= int'(presc_div)) begin
                    mcnt[s] = 0;
                    e.tick  = 1'b1;
                    nq = mq[s];
                    if (up) begin
                        if (mq[s] > limit) begin
                            e.tc = 1'b1;
                            nq   = sat ? limit : '0;
                        end else begin
                            boundary = (mq[s] == limit);
                            t        = ({1'b0, mq[s]} + (W+1)'(1)) % range;
                            e.tc     = boundary;
                            nq       = (sat && boundary) ? limit : t[W-1:0];
                        end
                    end else begin
                        if (mq[s] > limit) begin
                            nq = limit;
                        end else begin
                            boundary = (mq[s] == '0);
                            t        = ({1'b0, mq[s]} + {1'b0, limit}) % range;
                            e.tc     = boundary;
                            nq       = (sat && boundary) ? '0 : t[W-1:0];
                        end
                    end
                    mq[s] = nq;
                end else begin
                    mcnt[s]++;
                end
            end
            if (e.tc) movf[s] = 1'b1;
            else if (clear_ovf) movf[s] = 1'b0;
        end
        e.q   = mq[s];
        e.ovf = movf[s];
    endtask

    // Called with inputs already set; predicts the coming edge, then waits past it.
    task automatic cyc(input int n = 1);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            for (int s = 0; s < 2; s++) begin
                model_edge(s, e);
                exp_q[s].push_back(e);
            end
            @(negedge clk);
        end
    endtask

    task automatic quiet();
        reset = 1'b0; load = 1'b0; clear_ovf = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; cyc(1); reset = 1'b0;
    endtask

    // monitor: pops one expectation per DUT after every edge that had one queued
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q[0].size() > 0) begin
                e = exp_q[0].pop_front();
                check("wrap.q",    q_w,        e.q);
                check("wrap.tick", W'(tick_w), W'(e.tick));
                check("wrap.tc",   W'(tc_w),   W'(e.tc));
                check("wrap.ovf",  W'(ovf_w),  W'(e.ovf));
            end
            if (exp_q[1].size() > 0) begin
                e = exp_q[1].pop_front();
                check("sat.q",    q_s,        e.q);
                check("sat.tick", W'(tick_s), W'(e.tick));
                check("sat.tc",   W'(tc_s),   W'(e.tc));
                check("sat.ovf",  W'(ovf_s),  W'(e.ovf));
            end
        end
    end

    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; clear_ovf = 1'b0;
        load_val = '0; limit = '0; presc_div = '0;
        @(negedge clk);

        // modulo-6 up count with wrap
        reset = 1'b1; cyc(2); quiet();
        limit = W'(5); presc_div = '0; en = 1'b1; up = 1'b1;
        cyc(14);

        // prescaled count with an enable gap at p=2
        do_reset();
        limit = W'(255); presc_div = PW'(3); en = 1'b1;
        cyc(6);
        en = 1'b0; cyc(2);
        en = 1'b1; cyc(5);

        // saturation at the top, then count down
        do_reset();
        presc_div = '0; limit = W'(10); load_val = W'(9);
        load = 1'b1; cyc(1); load = 1'b0;
        up = 1'b1; cyc(4);
        up = 1'b0; cyc(3);

        // underflow wrap, clamped load, lowered limit
        do_reset();
        limit = W'(7); up = 1'b0; en = 1'b1; cyc(1);
        load_val = W'(200); load = 1'b1; cyc(1);
        load_val = W'(6); cyc(1); load = 1'b0;
        limit = W'(3); cyc(2);

        // clear_ovf racing a wrap; load beating en
        do_reset();
        limit = W'(5); up = 1'b1; load_val = W'(5);
        load = 1'b1; cyc(1); load = 1'b0;
        clear_ovf = 1'b1; cyc(1);
        cyc(1); clear_ovf = 1'b0;
        load_val = W'(2); load = 1'b1; en = 1'b1; cyc(1); load = 1'b0;

        // reset mid-prescale and mid-count, then full-range wrap
        presc_div = PW'(3); limit = '1; cyc(2);
        reset = 1'b1; cyc(1); reset = 1'b0;
        load_val = W'(31); load = 1'b1; cyc(1); load = 1'b0;
        reset = 1'b1; cyc(1); reset = 1'b0;
        load_val = '1; load = 1'b1; cyc(1); load = 1'b0;
        presc_div = '0; up = 1'b1; en = 1'b1; cyc(2);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 63) == 0);
            load      = ($urandom_range(0, 15) == 0);
            en        = ($urandom_range(0, 3) != 0);
            up        = $urandom_range(0, 1) != 0;
            clear_ovf = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0)
                limit = ($urandom_range(0, 9) == 0) ? '1 : W'($urandom_range(0, 12));
            if ($urandom_range(0, 15) == 0) presc_div = PW'($urandom_range(0, 3));
            load_val = ($urandom_range(0, 3) == 0) ? W'({$urandom(), $urandom(), $urandom()})
                                                   : W'($urandom_range(0, 15));
            cyc(1);
        end
        quiet(); en = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("drain.wrap", W'(exp_q[0].size()), '0);
        check("drain.sat",  W'(exp_q[1].size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_counter_gen.md
Name: sync_counter_gen

Overview:
Parametrised, fully synchronous up/down counter with programmable modulo limit, prescaler, parallel load, terminal-count pulse and sticky overflow flag. It is the next generation of the team's ripple T-flip-flop counter. All state changes on one clock edge, so there is no ripple skew and any bit can be used as a synchronous timebase. It sits in misc/ as the general timer/divider primitive for the rest of the design.

Parameters:
WIDTH, 65, counter width in bits (≥2).
PRESC_W, 8, prescaler width in bits (≥1).
SATURATE, 0, boundary mode: 0 = wrap, 1 = saturate at the boundary.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  count enable; gates both the prescaler and the counter.
up  input  1  direction: 1 = increment, 0 = decrement.
load  input  1  synchronous parallel load strobe.
load_val  input  WIDTH  value to load.
limit  input  WIDTH  modulo ceiling; count range is 0..limit inclusive.
presc_div  input  PRESC_W  prescaler; one step every presc_div+1 enabled cycles.
clear_ovf  input  1  clears the sticky ovf flag.
q  output  WIDTH  registered count value.
tick  output  1  registered; high for one cycle when a count step was applied.
tc  output  1  registered; high for one cycle when a step hit the boundary (wrap or saturate).
ovf  output  1  sticky; set on any tc event.

Behaviour:
- Interface: one clock `clk`. `reset` is synchronous and active-high. Polarity and synchronicity are fixed.
- Reset: on a clk edge with reset=1, q=0, prescaler p=0, tick=0, tc=0, ovf=0. Reset overrides every other input. Reset applied mid-count or mid-prescale discards all state.
- Priority per edge: reset > load > counting. clear_ovf is evaluated in parallel.
- Load (load=1): q <= min(load_val, limit). p <= 0. tick=0. tc=0. The en state is ignored. Load does not touch ovf.
- Prescaler: when en=1 and load=0:
  - If p == presc_div, a step occurs this edge and p <= 0.
  - Otherwise p <= p+1 and no step occurs.
  - presc_div=0 gives a step on every enabled cycle.
  - A presc_div change mid-count takes effect at the next compare. If p > presc_div, a step occurs and p <= 0.
- en=0: q, p and ovf hold. tick=0. tc=0.
- Step, up=1:
  - q < limit: q <= q+1.
  - q ≥ limit, wrap mode: q <= 0, tc=1.
  - q ≥ limit, saturate mode: q <= limit, tc=1.
- Step, up=0:
  - 0 < q ≤ limit: q <= q-1.
  - q == 0, wrap mode: q <= limit, tc=1.
  - q == 0, saturate mode: q stays 0, tc=1.
  - q > limit (limit lowered while running): q <= limit, no tc.
- Saturate mode: tc pulses on every step attempted while at the boundary, so it repeats while held there.
- tick: high on exactly the edges where a step was applied, aligned with the q update.
- Latency: q, tick and tc all update on the same edge as the step. Zero extra pipeline stages.
- limit=0: up steps give tc on every step with q=0. Down steps in wrap mode give q=0 and tc on every step.
- Full range: limit = all-ones gives a plain 2^WIDTH modulo counter. Arithmetic is unsigned, WIDTH bits, with no carry-out beyond tc.
- ovf: set on any edge where tc=1. Cleared by clear_ovf=1 only when no tc occurs on that same edge; set wins.
- Direction change mid-count takes effect on the next step. No extra latency.
- Outputs are registered only. There are no combinational paths from inputs to outputs.

Test Plan:
1. WIDTH=8, limit=5, presc_div=0, en=1, up=1 from reset -> q=0,1,2,3,4,5,0,… with tc=1 on each 5→0 edge; ovf=1 after the first wrap.
2. presc_div=3, limit=255, up=1 -> q increments every 4th enabled cycle with tick aligned to it; drop en for 2 cycles at p=2 -> q and p hold, and the step resumes after 1 more enabled cycle.
3. SATURATE=1, limit=10, load_val=9, load, then up steps -> q=9,10,10,10 with tc=1 on each held step; switch up=0 -> q=9,8,… with tc=0.
4. Wrap mode, up=0, q=0, limit=7 -> q=7 with tc=1. load_val=200 with limit=7 -> q=7. Lower limit to 3 while q=6 and take a down step -> q=3, tc=0.
5. Simultaneous events: clear_ovf=1 on a wrap edge -> ovf stays 1; clear_ovf on the next edge -> ovf=0. load and en on the same edge -> q=load_val, no step.
6. Assert reset mid-prescale (p=2) and mid-count (q=0x1F) -> next edge q=0, p=0, tick=0, tc=0, ovf=0. WIDTH=65 with limit all-ones, load_val all-ones, one up step -> q=0, tc=1.
